// File: rtl/ravenoc_pkg.sv
// Shared types and constants for the router output-link scheduler.
package ravenoc_pkg;

  localparam int unsigned N_VIRT_CHN = 3;

  typedef enum logic [1:0] {
    FlitHead     = 2'b00,
    FlitBody     = 2'b01,
    FlitTail     = 2'b10,
    FlitHeadTail = 2'b11
  } flit_t;

  localparam int unsigned ARB_FIXED_LOW   = 0;
  localparam int unsigned ARB_FIXED_HIGH  = 1;
  localparam int unsigned ARB_ROUND_ROBIN = 2;

  typedef enum logic {
    StIdle,
    StLocked
  } sched_state_t;

endpackage

// File: rtl/vc_credit_counter.sv
// Downstream credit counter for one virtual channel; saturates at CREDITS.
module vc_credit_counter #(
  parameter int unsigned CREDITS = 4,
  localparam int unsigned CW = $clog2(CREDITS + 1)
) (
  input  logic          clk_i,
  input  logic          arst_i,
  input  logic          consume_i,
  input  logic          credit_i,
  output logic [CW-1:0] count_o,
  output logic          has_credit_o,
  output logic          overflow_o
);

  localparam logic [CW-1:0] Full = CW'(CREDITS);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d    = count_q;
    overflow_o = 1'b0;
    if (consume_i && !credit_i) begin
      if (count_q != '0) count_d = count_q - CW'(1);
    end else if (credit_i && !consume_i) begin
      if (count_q == Full) overflow_o = 1'b1;
      else count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) count_q <= Full;
    else        count_q <= count_d;
  end

  assign count_o      = count_q;
  assign has_credit_o = (count_q != '0);

endmodule

// File: rtl/vc_link_scheduler.sv
// Output-link scheduler: arbitrates VC heads, locks a VC for a whole wormhole
// packet and gates every flit on downstream credits.
module vc_link_scheduler #(
  parameter int unsigned N_VIRT_CHN = ravenoc_pkg::N_VIRT_CHN,
  parameter int unsigned CREDITS    = 4,
  parameter int unsigned ARB_MODE   = ravenoc_pkg::ARB_FIXED_HIGH,
  localparam int unsigned VC_W = (N_VIRT_CHN > 1) ? $clog2(N_VIRT_CHN) : 1,
  localparam int unsigned CW   = $clog2(CREDITS + 1)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic [N_VIRT_CHN-1:0]    vc_valid_i,
  input  logic [2*N_VIRT_CHN-1:0]  vc_ftype_i,
  output logic [N_VIRT_CHN-1:0]    vc_ready_o,
  output logic                     out_valid_o,
  output logic [VC_W-1:0]          out_vc_id_o,
  input  logic                     out_ready_i,
  input  logic [N_VIRT_CHN-1:0]    credit_i,
  output logic [CW*N_VIRT_CHN-1:0] credit_cnt_o,
  output logic                     locked_o,
  output logic                     err_o
);
  import ravenoc_pkg::*;

  sched_state_t state_q, state_d;
  logic [VC_W-1:0] lock_vc_q, lock_vc_d;
  logic [VC_W-1:0] rr_ptr_q, rr_ptr_d;
  logic            err_q, err_d;

  logic [N_VIRT_CHN-1:0] has_credit, eligible, cand, credit_ovf;
  flit_t                 ftype [N_VIRT_CHN];
  logic                  proto_err, win_found, xfer;
  logic [VC_W-1:0]       win_idx;
  flit_t                 win_type;
  int                    j;

  assign eligible = vc_valid_i & has_credit;

  // Candidate filtering and protocol checks depend on the packet state.
  always_comb begin
    cand      = '0;
    proto_err = 1'b0;
    for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
      ftype[i] = flit_t'(vc_ftype_i[2*i +: 2]);
      if (state_q == StIdle) begin
        if (ftype[i] == FlitHead || ftype[i] == FlitHeadTail) cand[i] = eligible[i];
        else if (vc_valid_i[i]) proto_err = 1'b1;
      end else if (VC_W'(i) == lock_vc_q) begin
        cand[i] = eligible[i];
        if (vc_valid_i[i] && (ftype[i] == FlitHead || ftype[i] == FlitHeadTail)) begin
          proto_err = 1'b1;
        end
      end
    end
  end

  // The last match in each loop wins, so loop order encodes priority.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_type  = FlitHead;
    j         = 0;
    if (ARB_MODE == ARB_ROUND_ROBIN) begin
      for (int k = int'(N_VIRT_CHN) - 1; k >= 0; k--) begin
        j = int'(rr_ptr_q) + k;
        if (j >= int'(N_VIRT_CHN)) j = j - int'(N_VIRT_CHN);
        if (cand[j]) begin
          win_found = 1'b1;
          win_idx   = VC_W'(j);
          win_type  = ftype[j];
        end
      end
    end else if (ARB_MODE == ARB_FIXED_HIGH) begin
      for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = VC_W'(i);
          win_type  = ftype[i];
        end
      end
    end else begin
      for (int i = int'(N_VIRT_CHN) - 1; i >= 0; i--) begin
        if (cand[i]) begin
          win_found = 1'b1;
          win_idx   = VC_W'(i);
          win_type  = ftype[i];
        end
      end
    end
  end

  assign out_valid_o = win_found;
  assign out_vc_id_o = win_idx;
  assign xfer        = win_found & out_ready_i;

  always_comb begin
    for (int i = 0; i < int'(N_VIRT_CHN); i++) begin
      vc_ready_o[i] = xfer && (win_idx == VC_W'(i));
    end
  end

  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q | proto_err | (|credit_ovf);
    if (xfer) begin
      unique case (state_q)
        StIdle: begin
          if (win_type == FlitHead) begin
            state_d   = StLocked;
            lock_vc_d = win_idx;
          end
        end
        StLocked: begin
          if (win_type == FlitTail) state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
      if (win_type == FlitTail || win_type == FlitHeadTail) begin
        rr_ptr_d = (win_idx == VC_W'(N_VIRT_CHN - 1)) ? '0 : win_idx + VC_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q   <= StIdle;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
    end
  end

  assign locked_o = (state_q == StLocked);
  assign err_o    = err_q;

  for (genvar g = 0; g < int'(N_VIRT_CHN); g++) begin : g_credit
    vc_credit_counter #(
      .CREDITS(CREDITS)
    ) u_credit (
      .clk_i       (clk),
      .arst_i      (arst),
      .consume_i   (vc_ready_o[g]),
      .credit_i    (credit_i[g]),
      .count_o     (credit_cnt_o[CW*g +: CW]),
      .has_credit_o(has_credit[g]),
      .overflow_o  (credit_ovf[g])
    );
  end

endmodule

// File: tb/tb_vc_link_scheduler.sv
// Scoreboard bench: one scheduler per arbitration mode, fed by a shared VC FIFO model.
module tb_vc_link_scheduler;

  localparam logic [1:0] H = 2'b00, B = 2'b01, T = 2'b10, HT = 2'b11;

  typedef struct {
    int vc;
    int lk;  // 0/1 expected locked_o during the transfer, 2 = don't care
  } exp_t;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       tb_ready = 1'b1;
  logic [2:0] tb_valid = '0;
  logic [5:0] tb_ftype = '0;
  logic [2:0] tb_credit = '0;
  int         sel = 0;

  logic [2:0] dv [3];
  logic [2:0] dc [3];
  logic [2:0] vrdy [3];
  logic       ov [3];
  logic [1:0] vid [3];
  logic [8:0] ccnt [3];
  logic       lk [3];
  logic       er [3];

  int checks = 0;
  int errors = 0;
  exp_t exp_q[$];
  logic [1:0] fq0[$], fq1[$], fq2[$];
  logic [2:0] pop_pend = '0;
  exp_t       e;
  logic [2:0] oh;

  always #5 clk = ~clk;

  always_comb begin
    for (int d = 0; d < 3; d++) begin
      dv[d] = (sel == d) ? tb_valid : 3'b000;
      dc[d] = (sel == d) ? tb_credit : 3'b000;
    end
  end

  vc_link_scheduler #(.N_VIRT_CHN(3), .CREDITS(4), .ARB_MODE(0)) u_dut_lo (
    .clk(clk), .arst(arst), .vc_valid_i(dv[0]), .vc_ftype_i(tb_ftype), .vc_ready_o(vrdy[0]),
    .out_valid_o(ov[0]), .out_vc_id_o(vid[0]), .out_ready_i(tb_ready), .credit_i(dc[0]),
    .credit_cnt_o(ccnt[0]), .locked_o(lk[0]), .err_o(er[0]));

  vc_link_scheduler #(.N_VIRT_CHN(3), .CREDITS(4), .ARB_MODE(1)) u_dut_hi (
    .clk(clk), .arst(arst), .vc_valid_i(dv[1]), .vc_ftype_i(tb_ftype), .vc_ready_o(vrdy[1]),
    .out_valid_o(ov[1]), .out_vc_id_o(vid[1]), .out_ready_i(tb_ready), .credit_i(dc[1]),
    .credit_cnt_o(ccnt[1]), .locked_o(lk[1]), .err_o(er[1]));

  vc_link_scheduler #(.N_VIRT_CHN(3), .CREDITS(4), .ARB_MODE(2)) u_dut_rr (
    .clk(clk), .arst(arst), .vc_valid_i(dv[2]), .vc_ftype_i(tb_ftype), .vc_ready_o(vrdy[2]),
    .out_valid_o(ov[2]), .out_vc_id_o(vid[2]), .out_ready_i(tb_ready), .credit_i(dc[2]),
    .credit_cnt_o(ccnt[2]), .locked_o(lk[2]), .err_o(er[2]));

  // VC FIFO model: presents head flits, pops after the transfer edge.
  function automatic void refresh();
    tb_valid[0] = (fq0.size() > 0);
    tb_valid[1] = (fq1.size() > 0);
    tb_valid[2] = (fq2.size() > 0);
    tb_ftype[1:0] = (fq0.size() > 0) ? fq0[0] : 2'b00;
    tb_ftype[3:2] = (fq1.size() > 0) ? fq1[0] : 2'b00;
    tb_ftype[5:4] = (fq2.size() > 0) ? fq2[0] : 2'b00;
  endfunction

  task automatic push_flit(input int v, input logic [1:0] t);
    case (v)
      0: fq0.push_back(t);
      1: fq1.push_back(t);
      default: fq2.push_back(t);
    endcase
    refresh();
  endtask

  task automatic expect_xfer(input int v, input int l);
    exp_t x;
    x.vc = v;
    x.lk = l;
    exp_q.push_back(x);
  endtask

  always @(posedge clk) begin
    #1;
    if (pop_pend[0] && fq0.size() > 0) void'(fq0.pop_front());
    if (pop_pend[1] && fq1.size() > 0) void'(fq1.pop_front());
    if (pop_pend[2] && fq2.size() > 0) void'(fq2.pop_front());
    pop_pend = '0;
    refresh();
  end

  // Monitor: every link transfer is matched against the scoreboard.
  always @(negedge clk) begin
    if (arst) begin
      pop_pend = '0;
    end else begin
      pop_pend = vrdy[sel];
      if (ov[sel] && tb_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_xfer dut%0d got vc %0d required no transfer", sel, vid[sel]);
        end else begin
          e  = exp_q.pop_front();
          oh = 3'b001 << e.vc;
          if (vid[sel] !== 2'(e.vc) || vrdy[sel] !== oh || (e.lk < 2 && lk[sel] !== e.lk[0]))
          begin
            errors++;
            $display("FAIL xfer dut%0d got vc=%0d ready=%b locked=%b required vc=%0d ready=%b lk=%0d",
                     sel, vid[sel], vrdy[sel], lk[sel], e.vc, oh, e.lk);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %0d required %0d", name, act, req);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int cred(input int v);
    return int'(ccnt[sel][3*v +: 3]);
  endfunction

  task automatic wait_left(input int n, input int budget);
    int c = 0;
    while (exp_q.size() > n && c < budget) begin
      cyc(1);
      c++;
    end
    if (exp_q.size() > n) begin
      checks++;
      errors++;
      $display("FAIL timeout dut%0d got %0d pending required %0d", sel, exp_q.size(), n);
      exp_q.delete();
    end
  endtask

  task automatic reset_dut(input int d);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover got %0d pending required 0", exp_q.size());
      exp_q.delete();
    end
    arst = 1'b1;
    fq0.delete();
    fq1.delete();
    fq2.delete();
    refresh();
    sel = d;
    cyc(2);
    arst = 1'b0;
    cyc(1);
  endtask

  initial begin
    // Fixed-high: reset values, then VC2 beats VC0.
    reset_dut(1);
    @(negedge clk);
    chk("rst_out_valid", int'(ov[1]), 0);
    chk("rst_vc_id", int'(vid[1]), 0);
    chk("rst_vc_ready", int'(vrdy[1]), 0);
    chk("rst_locked", int'(lk[1]), 0);
    chk("rst_err", int'(er[1]), 0);
    chk("rst_credits", int'(ccnt[1]), 9'b100_100_100);
    cyc(1);
    push_flit(0, HT);
    push_flit(2, HT);
    expect_xfer(2, 0);
    expect_xfer(0, 0);
    wait_left(0, 10);
    chk("hi_credit0", cred(0), 3);
    chk("hi_credit1", cred(1), 4);
    chk("hi_credit2", cred(2), 3);

    // Fixed-low: packet lock on VC1 holds off VC2.
    reset_dut(0);
    push_flit(1, H);
    push_flit(1, B);
    push_flit(1, T);
    push_flit(2, HT);
    expect_xfer(1, 0);
    expect_xfer(1, 1);
    expect_xfer(1, 1);
    expect_xfer(2, 0);
    wait_left(0, 12);
    chk("lock_released", int'(lk[0]), 0);
    push_flit(0, HT);
    push_flit(2, HT);
    expect_xfer(0, 0);
    expect_xfer(2, 0);
    wait_left(0, 10);

    // Credit stall on VC0 and release by one credit pulse.
    reset_dut(0);
    for (int n = 0; n < 5; n++) begin
      push_flit(0, HT);
      expect_xfer(0, 0);
    end
    wait_left(1, 12);
    cyc(2);
    @(negedge clk);
    chk("stall_out_valid", int'(ov[0]), 0);
    chk("stall_credit0", cred(0), 0);
    cyc(1);
    tb_credit = 3'b001;
    cyc(1);
    tb_credit = 3'b000;
    wait_left(0, 4);
    @(negedge clk);
    chk("stall_after_credit0", cred(0), 0);
    chk("stall_err", int'(er[0]), 0);

    // Round-robin across three always-valid VCs.
    reset_dut(2);
    for (int n = 0; n < 2; n++) begin
      push_flit(0, HT);
      push_flit(1, HT);
      push_flit(2, HT);
    end
    for (int n = 0; n < 6; n++) expect_xfer(n % 3, 0);
    wait_left(0, 12);

    // Simultaneous consume and return on VC1, then overflow on full VC0.
    reset_dut(2);
    push_flit(1, HT);
    expect_xfer(1, 0);
    wait_left(0, 4);
    chk("sim_pre_credit1", cred(1), 3);
    push_flit(1, HT);
    expect_xfer(1, 0);
    tb_credit = 3'b010;
    cyc(1);
    tb_credit = 3'b000;
    wait_left(0, 4);
    @(negedge clk);
    chk("sim_credit1", cred(1), 3);
    chk("sim_err", int'(er[2]), 0);
    cyc(1);
    tb_credit = 3'b001;
    cyc(1);
    tb_credit = 3'b000;
    @(negedge clk);
    chk("ovf_credit0", cred(0), 4);
    chk("ovf_err", int'(er[2]), 1);
    cyc(2);
    chk("ovf_err_sticky", int'(er[2]), 1);

    // BODY presented in IDLE: ignored, not popped, flagged.
    reset_dut(1);
    push_flit(0, B);
    @(negedge clk);
    chk("body_idle_valid", int'(ov[1]), 0);
    chk("body_idle_ready", int'(vrdy[1]), 0);
    cyc(1);
    @(negedge clk);
    chk("body_idle_err", int'(er[1]), 1);

    // Reset in the middle of a packet.
    reset_dut(0);
    push_flit(1, H);
    expect_xfer(1, 0);
    wait_left(0, 4);
    tb_credit = 3'b001;
    cyc(1);
    tb_credit = 3'b000;
    @(negedge clk);
    chk("mid_locked", int'(lk[0]), 1);
    chk("mid_credit1", cred(1), 3);
    chk("mid_err_set", int'(er[0]), 1);
    cyc(1);
    arst = 1'b1;
    fq0.delete();
    fq1.delete();
    fq2.delete();
    refresh();
    @(negedge clk);
    chk("mid_rst_locked", int'(lk[0]), 0);
    chk("mid_rst_credits", int'(ccnt[0]), 9'b100_100_100);
    chk("mid_rst_err", int'(er[0]), 0);
    cyc(1);
    arst = 1'b0;
    cyc(1);
    push_flit(2, H);
    expect_xfer(2, 0);
    wait_left(0, 4);
    @(negedge clk);
    chk("mid_new_locked", int'(lk[0]), 1);
    chk("mid_new_credit2", cred(2), 3);

    cyc(2);
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL final_pending got %0d required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
